// File: rtl/bullet_controller.sv
// Player bullet: spawn on fire edge, climb each tick, retire on top exit or kill.
// Also renders the bullet sprite window and keeps a saturating hit count.
module bullet_controller #(
  parameter int MAP_HEIGHT = 480,
  parameter int PLAYER_W = 80,
  parameter int BLT_W = 10,
  parameter int BLT_H = 10,
  parameter int SPD_Y = 12,
  parameter int COOLDOWN = 4,
  parameter logic [1:0] GAME_STATE = 2'd2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] h_cnt,
  input  logic [9:0] v_cnt,
  input  logic [1:0] state,
  input  logic       fire,
  input  logic [9:0] player_x,
  input  logic [9:0] player_y,
  input  logic       mon_alive,
  input  logic [9:0] mon_y,
  output logic       blt_exist,
  output logic [9:0] blt_x,
  output logic [9:0] blt_y,
  output logic [7:0] hits,
  output logic       valid,
  output logic [6:0] pixel_addr
);

  localparam logic [9:0] MAP_H = 10'(MAP_HEIGHT);
  localparam logic [9:0] X_OFS = 10'(PLAYER_W / 2 - BLT_W / 2);
  localparam logic [9:0] BH = 10'(BLT_H);
  localparam logic [9:0] SPD = 10'(SPD_Y);
  localparam logic [7:0] CD = 8'(COOLDOWN);

  typedef enum logic [1:0] {IDLE, FLY, COOL} st_t;

  st_t        st, st_n;
  logic       exist_n;
  logic [9:0] x_n, y_n;
  logic [7:0] hits_n;
  logic [7:0] cnt, cnt_n;
  logic       fire_d, mon_d;
  logic       fire_pulse, hit;

  assign fire_pulse = fire & ~fire_d;
  // Monster dropping off the bottom also clears mon_alive; not a kill.
  assign hit = blt_exist & mon_d & ~mon_alive & (mon_y < MAP_H);

  always_ff @(posedge clk) begin
    fire_d <= fire;
    if (rst || state != GAME_STATE) begin
      st        <= IDLE;
      blt_exist <= 1'b0;
      blt_x     <= '0;
      blt_y     <= '0;
      hits      <= '0;
      cnt       <= '0;
      mon_d     <= 1'b0;
    end else begin
      st        <= st_n;
      blt_exist <= exist_n;
      blt_x     <= x_n;
      blt_y     <= y_n;
      hits      <= hits_n;
      cnt       <= cnt_n;
      mon_d     <= mon_alive;
    end
  end

  always_comb begin
    st_n    = st;
    exist_n = blt_exist;
    x_n     = blt_x;
    y_n     = blt_y;
    hits_n  = hits;
    cnt_n   = cnt;
    unique case (st)
      IDLE: begin
        exist_n = 1'b0;
        if (fire_pulse) begin
          x_n     = player_x + X_OFS;
          y_n     = (player_y >= BH) ? player_y - BH : '0;
          exist_n = 1'b1;
          st_n    = FLY;
        end
      end
      FLY: begin
        if (blt_y < SPD) begin
          exist_n = 1'b0;
          st_n    = COOL;
          cnt_n   = CD;
        end else if (hit) begin
          exist_n = 1'b0;
          st_n    = COOL;
          cnt_n   = CD;
          if (hits != 8'hFF)
            hits_n = hits + 8'd1;
        end else begin
          y_n = blt_y - SPD;
        end
      end
      COOL: begin
        if (cnt == 8'd1) begin
          st_n  = IDLE;
          cnt_n = '0;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      default: st_n = IDLE;
    endcase
  end

  // Sprite window; 11-bit bounds avoid wrap near the right/bottom edge.
  always_comb begin
    valid = blt_exist
      && h_cnt >= blt_x
      && {1'b0, h_cnt} < {1'b0, blt_x} + 11'(BLT_W)
      && v_cnt >= blt_y
      && {1'b0, v_cnt} < {1'b0, blt_y} + 11'(BLT_H);
    pixel_addr = '0;
    if (valid)
      pixel_addr = 7'(h_cnt - blt_x)
        + 7'(v_cnt - blt_y) * 7'(BLT_W);
  end

endmodule

// File: tb/tb_bullet_controller.sv
// Directed bench for bullet_controller with a per-cycle reference model.
// Literal checks pin key moments; a compare process checks every negedge.
module tb_bullet_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] h_cnt, v_cnt;
  logic [1:0] state;
  logic       fire;
  logic [9:0] player_x, player_y;
  logic       mon_alive;
  logic [9:0] mon_y;
  logic       blt_exist;
  logic [9:0] blt_x, blt_y;
  logic [7:0] hits;
  logic       valid;
  logic [6:0] pixel_addr;

  int n_checks = 0;
  int n_fail = 0;
  bit run = 1'b0;

  bullet_controller dut (
    .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .state(state), .fire(fire),
    .player_x(player_x), .player_y(player_y),
    .mon_alive(mon_alive), .mon_y(mon_y),
    .blt_exist(blt_exist), .blt_x(blt_x), .blt_y(blt_y),
    .hits(hits), .valid(valid), .pixel_addr(pixel_addr)
  );

  always #5 clk = ~clk;

  // Reference model: bullet as position + alive flag, cooldown as ticks left.
  logic       m_exist, m_fire_d, m_mon_d;
  int         m_x, m_y, m_hits, m_cool;

  always @(posedge clk) begin
    m_fire_d <= fire;
    if (rst || state != 2'd2) begin
      m_exist <= 1'b0; m_x <= 0; m_y <= 0;
      m_hits <= 0; m_cool <= 0; m_mon_d <= 1'b0;
    end else begin
      m_mon_d <= mon_alive;
      if (m_exist) begin
        if (m_y < 12) begin
          m_exist <= 1'b0; m_cool <= 4;
        end else if (m_mon_d && !mon_alive && mon_y < 480) begin
          m_exist <= 1'b0; m_cool <= 4;
          m_hits <= (m_hits >= 255) ? 255 : m_hits + 1;
        end else begin
          m_y <= m_y - 12;
        end
      end else if (m_cool > 0) begin
        m_cool <= m_cool - 1;
      end else if (fire && !m_fire_d) begin
        m_exist <= 1'b1;
        m_x <= (int'(player_x) + 35) % 1024;
        m_y <= (player_y >= 10) ? int'(player_y) - 10 : 0;
      end
    end
  end

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      bit mv;
      int ma;
      mv = m_exist && h_cnt >= m_x && h_cnt < m_x + 10
        && v_cnt >= m_y && v_cnt < m_y + 10;
      ma = mv ? (h_cnt - m_x) + (v_cnt - m_y) * 10 : 0;
      cmp("m_exist", 32'(blt_exist), 32'(m_exist));
      cmp("m_x", 32'(blt_x), 32'(m_x));
      cmp("m_y", 32'(blt_y), 32'(m_y));
      cmp("m_hits", 32'(hits), 32'(m_hits));
      cmp("m_valid", 32'(valid), 32'(mv));
      cmp("m_addr", 32'(pixel_addr), 32'(ma));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_hit();
    fire = 1'b1; mon_alive = 1'b1; tick();
    mon_alive = 1'b0; mon_y = 10'd100; tick();
    fire = 1'b0; mon_alive = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    rst = 1'b1; state = 2'd2; fire = 1'b1;
    h_cnt = '0; v_cnt = '0;
    player_x = 10'd200; player_y = 10'd300;
    mon_alive = 1'b0; mon_y = 10'd100;
    repeat (3) tick();
    run = 1'b1;
    cmp("rst_exist", 32'(blt_exist), 0);
    cmp("rst_x", 32'(blt_x), 0);
    cmp("rst_y", 32'(blt_y), 0);
    cmp("rst_hits", 32'(hits), 0);

    rst = 1'b0;
    repeat (3) tick();
    cmp("held_key", 32'(blt_exist), 0);

    fire = 1'b0; tick();
    fire = 1'b1; tick();
    cmp("spawn_exist", 32'(blt_exist), 1);
    cmp("spawn_x", 32'(blt_x), 235);
    cmp("spawn_y", 32'(blt_y), 290);

    h_cnt = 10'd235; v_cnt = 10'd290; #1;
    cmp("win_tl_valid", 32'(valid), 1);
    cmp("win_tl_addr", 32'(pixel_addr), 0);
    h_cnt = 10'd244; v_cnt = 10'd299; #1;
    cmp("win_br_valid", 32'(valid), 1);
    cmp("win_br_addr", 32'(pixel_addr), 99);
    h_cnt = 10'd245; #1;
    cmp("win_out_valid", 32'(valid), 0);
    cmp("win_out_addr", 32'(pixel_addr), 0);
    h_cnt = '0; v_cnt = '0;

    // Flight with a fire pulse mid-air that must be ignored.
    for (int k = 1; k <= 24; k++) begin
      fire = (k == 10);
      tick();
      cmp("fly_y", 32'(blt_y), 32'(290 - 12 * k));
    end
    cmp("fly_end_y", 32'(blt_y), 2);
    tick();
    cmp("top_retire", 32'(blt_exist), 0);
    fire = 1'b1; tick();
    fire = 1'b0; tick();
    cmp("cool_pulse", 32'(blt_exist), 0);
    repeat (2) tick();
    cmp("cool_end", 32'(blt_exist), 0);
    fire = 1'b1; tick();
    cmp("idle_first_fire", 32'(blt_exist), 1);

    mon_alive = 1'b1; tick();
    fire = 1'b0; mon_alive = 1'b0; mon_y = 10'd100; tick();
    cmp("hit_exist", 32'(blt_exist), 0);
    cmp("hit_count", 32'(hits), 1);
    mon_alive = 1'b1;
    repeat (4) tick();
    for (int i = 0; i < 299; i++) do_hit();
    cmp("hits_sat", 32'(hits), 255);

    fire = 1'b1; mon_alive = 1'b1; tick();
    fire = 1'b0; tick();
    mon_alive = 1'b0; mon_y = 10'd480; tick();
    cmp("false_hit_exist", 32'(blt_exist), 1);
    cmp("false_hit_y", 32'(blt_y), 266);
    cmp("false_hit_hits", 32'(hits), 255);
    mon_alive = 1'b1; mon_y = 10'd100;

    state = 2'd0; tick();
    cmp("abort_exist", 32'(blt_exist), 0);
    cmp("abort_x", 32'(blt_x), 0);
    cmp("abort_y", 32'(blt_y), 0);
    cmp("abort_hits", 32'(hits), 0);
    state = 2'd2; tick();

    player_y = 10'd5;
    fire = 1'b1; tick();
    cmp("clamp_exist", 32'(blt_exist), 1);
    cmp("clamp_y", 32'(blt_y), 0);
    fire = 1'b0; tick();
    cmp("clamp_retire", 32'(blt_exist), 0);
    repeat (4) tick();

    // Top exit wins over a simultaneous kill.
    do_hit();
    cmp("prio_hits", 32'(hits), 0);
    player_y = 10'd300;
    do_hit();
    cmp("restart_hits", 32'(hits), 1);

    tick();
    run = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_checks, n_fail);
    $finish;
  end

endmodule
